// File: rtl/icache_direct_pkg.sv
// icache_direct_pkg: shared configuration for the direct-mapped instruction cache.
//   Addrlen / Instlen    : default address and instruction widths
//   ICACHE_INDEX_BITS    : default line index width (2^7 = 128 lines)
//   icache_state_e       : miss-handling FSM encoding (IDLE / MISS / DISCARD)
package icache_direct_pkg;

    localparam int Addrlen           = 32;
    localparam int Instlen           = 32;
    localparam int ICACHE_INDEX_BITS = 7;

    typedef enum logic [1:0] {
        ICACHE_IDLE    = 2'd0,
        ICACHE_MISS    = 2'd1,
        ICACHE_DISCARD = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage for the direct-mapped icache.
//   clk, rst      : clock, asynchronous active-low reset (clears valid bits only)
//   i_rd_idx      : combinational read index
//   o_rd_valid/o_rd_tag/o_rd_data : line contents at i_rd_idx, same cycle
//   i_we, i_wr_idx, i_wr_tag, i_wr_data : single write port, sets valid
module icache_array
    import icache_direct_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_W      = 9,
    parameter int DATA_W     = Instlen
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] i_rd_idx,
    output logic                  o_rd_valid,
    output logic [TAG_W-1:0]      o_rd_tag,
    output logic [DATA_W-1:0]     o_rd_data,
    input  logic                  i_we,
    input  logic [INDEX_BITS-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]      i_wr_tag,
    input  logic [DATA_W-1:0]     i_wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    // Only the valid bits need reset; tag/data are don't-care until valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-line instruction cache between
// ifetch and mem_ctrl. Hits answer combinationally; misses issue one word
// refill that always runs to completion (a flush only cancels delivery).
//   clk, rst            : clock, asynchronous active-low reset
//   rdy                 : global ready, low freezes all state
//   flush               : mispredict, cancels the current fetch
//   if_req, if_addr     : fetch request / PC (bits [1:0] ignored)
//   if_valid, if_inst   : instruction valid for if_addr this cycle
//   mem_req, mem_addr   : level refill request, held until mem_done
//   mem_done, mem_data  : refill completion pulse and word
// Optional: define ICACHE_STATS_EN to add saturating hit_cnt / miss_cnt outputs.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int INDEX_BITS    = ICACHE_INDEX_BITS,
    parameter int ADDR_W        = Addrlen,
    parameter int MEM_SPAN_BITS = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [31:0]       if_inst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_done,
    input  logic [31:0]       mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int TAG_W = MEM_SPAN_BITS - INDEX_BITS - 2;

    icache_state_e         r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_miss_addr;

    logic [INDEX_BITS-1:0] w_idx, w_fill_idx;
    logic [TAG_W-1:0]      w_tag, w_fill_tag, w_rd_tag;
    logic                  w_rd_valid;
    logic [31:0]           w_rd_data;
    logic                  w_done, w_hit, w_start, w_fill, w_match, w_deliver;
    logic                  w_unused_ok;

    assign w_idx      = if_addr[INDEX_BITS+1:2];
    assign w_tag      = if_addr[MEM_SPAN_BITS-1:INDEX_BITS+2];
    assign w_fill_idx = r_miss_addr[INDEX_BITS+1:2];
    assign w_fill_tag = r_miss_addr[MEM_SPAN_BITS-1:INDEX_BITS+2];
    assign w_unused_ok = ^if_addr[1:0];

    // mem_ctrl is frozen by the same rdy, so a done seen while rdy=0 is ignored.
    assign w_done  = mem_done & rdy;
    assign w_match = (if_addr[ADDR_W-1:2] == r_miss_addr[ADDR_W-1:2]);
    assign w_hit   = if_req & w_rd_valid & (w_rd_tag == w_tag)
                   & (r_state == ICACHE_IDLE) & ~flush;
    assign w_fill  = w_done & (r_state != ICACHE_IDLE);

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W),
        .DATA_W     (32)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_we       (w_fill),
        .i_wr_idx   (w_fill_idx),
        .i_wr_tag   (w_fill_tag),
        .i_wr_data  (mem_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ICACHE_IDLE;
            r_miss_addr <= '0;
        end else if (rdy) begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_miss_addr <= {if_addr[ADDR_W-1:2], 2'b00};
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_deliver   = 1'b0;
        case (r_state)
            ICACHE_IDLE: begin
                if (if_req & ~w_hit & ~flush) begin
                    w_start     = 1'b1;
                    w_state_nxt = ICACHE_MISS;
                end
            end
            ICACHE_MISS: begin
                if (w_done) begin
                    // Forward only if ifetch is still asking for this word.
                    w_deliver   = if_req & w_match & ~flush;
                    w_state_nxt = ICACHE_IDLE;
                end else if (flush) begin
                    w_state_nxt = ICACHE_DISCARD;
                end
            end
            ICACHE_DISCARD: begin
                if (w_done) begin
                    w_state_nxt = ICACHE_IDLE;
                end
            end
            default: w_state_nxt = ICACHE_IDLE;
        endcase
    end

    always_comb begin
        if_valid = w_hit | w_deliver;
        if_inst  = '0;
        if (w_hit) begin
            if_inst = w_rd_data;
        end else if (w_deliver) begin
            if_inst = mem_data;
        end
    end

    assign mem_req  = (r_state != ICACHE_IDLE);
    assign mem_addr = r_miss_addr;

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (rdy) begin
            if (w_hit && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_start && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_direct.sv
`timescale 1ns/1ps
// Bench for icache_direct: a line-level model (which address each line holds,
// plus one outstanding refill with a cancelled flag) is checked every cycle,
// alongside directed literal expectations for each scenario.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done = 1'b0;
    logic [31:0] mem_data = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    icache_direct dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .flush    (flush),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_valid (if_valid),
        .if_inst  (if_inst),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_done (mem_done),
        .mem_data (mem_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // 128 lines of one word; a line remembers the word address (within the
    // 18-bit span) it holds. One refill may be outstanding.
    bit          m_valid [128];
    logic [15:0] m_word  [128];
    logic [31:0] m_data  [128];
    bit          m_busy;
    bit          m_cancel;
    logic [31:0] m_addr;
    int unsigned m_hits, m_misses;

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) % 128);
    endfunction

    function automatic bit m_hit();
        int l;
        l = line_of(if_addr);
        return !m_busy && if_req && !flush && m_valid[l] && (m_word[l] == if_addr[17:2]);
    endfunction

    function automatic bit m_deliver();
        return m_busy && !m_cancel && rdy && mem_done && if_req && !flush
            && ((if_addr >> 2) == (m_addr >> 2));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 128; i++) m_valid[i] <= 1'b0;
            m_busy   <= 1'b0;
            m_cancel <= 1'b0;
            m_addr   <= '0;
            m_hits   <= 0;
            m_misses <= 0;
        end else if (rdy) begin
            if (m_hit()) m_hits <= m_hits + 1;
            if (!m_busy) begin
                if (if_req && !flush && !m_hit()) begin
                    m_busy   <= 1'b1;
                    m_cancel <= 1'b0;
                    m_addr   <= if_addr & ~32'd3;
                    m_misses <= m_misses + 1;
                end
            end else if (mem_done) begin
                m_valid[line_of(m_addr)] <= 1'b1;
                m_word[line_of(m_addr)]  <= m_addr[17:2];
                m_data[line_of(m_addr)]  <= mem_data;
                m_busy <= 1'b0;
            end else if (flush) begin
                m_cancel <= 1'b1;
            end
        end
    end

    // Compare process: outputs are combinational, inputs change just after
    // posedge, so the falling edge sees settled values.
    always @(negedge clk) begin
        logic        e_valid;
        logic [31:0] e_inst;
        e_valid = m_hit() || m_deliver();
        e_inst  = m_hit() ? m_data[line_of(if_addr)] : (m_deliver() ? mem_data : 32'd0);
        chk("mdl_if_valid", 64'(if_valid), 64'(e_valid));
        if (e_valid || !rst) chk("mdl_if_inst", 64'(if_inst), 64'(e_inst));
        chk("mdl_mem_req", 64'(mem_req), 64'(m_busy));
        if (m_busy || !rst) chk("mdl_mem_addr", 64'(mem_addr), 64'(m_addr));
`ifdef ICACHE_STATS_EN
        chk("mdl_hit_cnt", 64'(hit_cnt), 64'(m_hits));
        chk("mdl_miss_cnt", 64'(miss_cnt), 64'(m_misses));
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit r, input logic [31:0] a, input bit f,
                          input bit d, input logic [31:0] dat);
        if_req   = r;
        if_addr  = a;
        flush    = f;
        mem_done = d;
        mem_data = dat;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_if_inst", 64'(if_inst), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        tick();
        rst = 1'b1;

        // cold miss on 0x100, refill forwarded, then a same-cycle hit
        set_in(1, 32'h100, 0, 0, 0);
        @(negedge clk); chk("cold_valid", 64'(if_valid), 64'd0); chk("cold_req", 64'(mem_req), 64'd0);
        tick();
        @(negedge clk); chk("miss_req", 64'(mem_req), 64'd1); chk("miss_addr", 64'(mem_addr), 64'h100);
        tick();
        set_in(1, 32'h100, 0, 1, 32'h93);
        @(negedge clk); chk("fwd_valid", 64'(if_valid), 64'd1); chk("fwd_inst", 64'(if_inst), 64'h93);
        tick();
        set_in(1, 32'h100, 0, 0, 0);
        @(negedge clk); chk("hit_valid", 64'(if_valid), 64'd1); chk("hit_inst", 64'(if_inst), 64'h93);
        chk("hit_noreq", 64'(mem_req), 64'd0);
        tick();

        // conflict: 0x300 shares the line with 0x100
        set_in(1, 32'h300, 0, 0, 0);
        @(negedge clk); chk("conf_valid", 64'(if_valid), 64'd0);
        tick(); tick();
        set_in(1, 32'h300, 0, 1, 32'hDEADBEEF);
        @(negedge clk); chk("conf_inst", 64'(if_inst), 64'hDEADBEEF);
        tick();
        set_in(1, 32'h100, 0, 0, 0);
        @(negedge clk); chk("evict_miss", 64'(if_valid), 64'd0);
        tick();
        // ifetch moved on: refill fills 0x100 but is not forwarded
        set_in(1, 32'h104, 0, 1, 32'h93);
        @(negedge clk); chk("moved_valid", 64'(if_valid), 64'd0);
        tick();
        set_in(1, 32'h100, 0, 0, 0);
        @(negedge clk); chk("refill_hit", 64'(if_inst), 64'h93);
        tick();

        // flush in MISS before mem_done: refill completes silently
        set_in(1, 32'h200, 0, 0, 0); tick();
        set_in(1, 32'h200, 1, 0, 0);
        @(negedge clk); chk("fl_valid", 64'(if_valid), 64'd0);
        tick();
        set_in(1, 32'h200, 0, 0, 0);
        @(negedge clk); chk("disc_req", 64'(mem_req), 64'd1);
        tick();
        set_in(1, 32'h200, 0, 1, 32'h13);
        @(negedge clk); chk("disc_valid", 64'(if_valid), 64'd0);
        tick();
        set_in(1, 32'h200, 0, 0, 0);
        @(negedge clk); chk("disc_hit", 64'(if_inst), 64'h13); chk("disc_hit_v", 64'(if_valid), 64'd1);
        tick();

        // flush together with mem_done
        set_in(1, 32'h208, 0, 0, 0); tick(); tick();
        set_in(1, 32'h208, 1, 1, 32'h17);
        @(negedge clk); chk("fldone_valid", 64'(if_valid), 64'd0);
        tick();
        set_in(1, 32'h208, 0, 0, 0);
        @(negedge clk); chk("fldone_idle", 64'(mem_req), 64'd0); chk("fldone_hit", 64'(if_inst), 64'h17);
        tick();

        // rdy=0 mid-MISS, with a mem_done pulse that must be ignored
        set_in(1, 32'h400, 0, 0, 0); tick();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(1, 32'h400, 0, (i == 2), 32'h55);
            @(negedge clk); chk("frz_req", 64'(mem_req), 64'd1); chk("frz_valid", 64'(if_valid), 64'd0);
            tick();
        end
        rdy = 1'b1;
        set_in(1, 32'h400, 0, 0, 0); tick();
        set_in(1, 32'h400, 0, 1, 32'h66);
        @(negedge clk); chk("thaw_inst", 64'(if_inst), 64'h66);
        tick();
        set_in(1, 32'h400, 0, 0, 0);
        @(negedge clk); chk("thaw_hit", 64'(if_inst), 64'h66);
        tick();

        // flush in IDLE: no delivery, no miss started
        set_in(1, 32'h100, 1, 0, 0);
        @(negedge clk); chk("idlefl_valid", 64'(if_valid), 64'd0);
        tick();
        set_in(1, 32'h500, 1, 0, 0); tick();
        set_in(0, 32'h0, 0, 0, 0);
        @(negedge clk); chk("idlefl_nomiss", 64'(mem_req), 64'd0);
        tick();

        // alias above the meaningful span
        set_in(1, 32'h0004_0100, 0, 0, 0);
        @(negedge clk); chk("alias_hit", 64'(if_inst), 64'h93);
        tick();

        // last line, ignored low bits, back-to-back misses
        set_in(1, 32'h1FC, 0, 0, 0); tick(); tick();
        set_in(1, 32'h1FE, 0, 1, 32'hAA);
        @(negedge clk); chk("last_fwd", 64'(if_inst), 64'hAA);
        tick();
        set_in(1, 32'h3FC, 0, 0, 0);
        @(negedge clk); chk("b2b_gap", 64'(mem_req), 64'd0);
        tick(); tick();
        set_in(1, 32'h3FC, 0, 1, 32'hBB); tick();
        set_in(1, 32'h1FD, 0, 0, 0);
        @(negedge clk); chk("last_evicted", 64'(if_valid), 64'd0);
        tick(); tick();
        set_in(0, 32'h0, 0, 1, 32'hAA); tick();
        set_in(0, 32'h0, 0, 0, 0); tick();

        // async reset mid-MISS
        set_in(1, 32'h500, 0, 0, 0); tick(); tick();
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("arst_req", 64'(mem_req), 64'd0);
        chk("arst_addr", 64'(mem_addr), 64'd0);
        chk("arst_valid", 64'(if_valid), 64'd0);
`ifdef ICACHE_STATS_EN
        chk("arst_hits", 64'(hit_cnt), 64'd0);
        chk("arst_misses", 64'(miss_cnt), 64'd0);
`endif
        set_in(0, 32'h0, 0, 0, 0);
        tick();
        rst = 1'b1;
        set_in(1, 32'h100, 0, 0, 0);
        @(negedge clk); chk("arst_lines_inv", 64'(if_valid), 64'd0);
        tick();
        set_in(0, 32'h0, 0, 0, 0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
